cgra_mem_port_ctrl: RTL
=======================

Name: cgra_mem_port_ctrl

Overview:
- Bus-side front end placed directly upstream of one CGRA SRAM bank wrapper.
- Accepts OBI-style req/gnt/rvalid transactions and drives the bank's req/we/addr/wdata/be pins.
- Returns read data with fixed one-cycle latency.
- Contains an idle-driven retention sequencer. It drops the bank into retention after a programmable idle period and performs a timed wake-up before granting the next access.

Parameters:
- NUM_WORDS, 1024, words in the attached bank.
- DATA_WIDTH, 32, data width. Fixed at 32 with 4 byte enables.
- IDLE_CYCLES, 64, consecutive idle cycles before retention entry. Must be >= 2.
- WAKE_CYCLES, 4, cycles held in WAKE after retention exit before grants resume. Must be >= 1.
- AddrWidth (localparam), (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- req_i  in  1  bus request
- gnt_o  out  1  bus grant
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AddrWidth  word address
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- rvalid_o  out  1  response valid, one cycle after grant
- rdata_o  out  32  read data, valid with rvalid_o
- ret_en_i  in  1  enables automatic retention
- retentive_o  out  1  1 while state is RETENTIVE
- mem_req_o  out  1  bank request
- mem_we_o  out  1  bank write enable
- mem_addr_o  out  AddrWidth  bank address
- mem_wdata_o  out  32  bank write data
- mem_be_o  out  4  bank byte enables
- mem_set_retentive_o  out  1  active-low retention control; 0 = bank retentive
- mem_rdata_i  in  32  bank read data, valid one cycle after a read request

Behaviour:
Reset and clock:
- One clock clk_i. Reset rst_ni is synchronous and active-low.
- Reset values: state = ACTIVE, idle_cnt = 0, wake_cnt = 0, gnt_o = 0 (combinational, req_i low), rvalid_o = 0, rdata_o = 0, retentive_o = 0, mem_req_o = 0, mem_set_retentive_o = 1.
- Reset asserted mid-WAKE or mid-RETENTIVE returns the block to ACTIVE with the bank non-retentive on the next edge. Any pending rvalid is dropped.

Access path:
- gnt_o = req_i & (state == ACTIVE). Grant is combinational with zero wait states in ACTIVE.
- mem_req_o = gnt_o. mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o are combinational pass-throughs of the bus inputs.
- rvalid_o is registered: asserted the cycle after every granted request, for both reads and writes.
- Read: rdata_o = mem_rdata_i while rvalid_o is high.
- Write response: rdata_o = 0.
- Back-to-back requests are granted every cycle, giving full throughput.

Retention FSM:
- States: ACTIVE, RETENTIVE, WAKE.
- ACTIVE:
  - idle_cnt clears on any cycle with req_i = 1 or ret_en_i = 0; otherwise it increments and saturates at IDLE_CYCLES-1.
  - Transition to RETENTIVE when idle_cnt == IDLE_CYCLES-1 & req_i == 0 & ret_en_i == 1.
  - No outstanding rvalid is possible at entry, because IDLE_CYCLES >= 2.
- RETENTIVE:
  - mem_set_retentive_o = 0, retentive_o = 1, gnt_o = 0.
  - Transition to WAKE on req_i = 1 or ret_en_i = 0. Load wake_cnt = WAKE_CYCLES-1.
- WAKE:
  - mem_set_retentive_o = 1, gnt_o = 0. wake_cnt decrements each cycle.
  - Transition to ACTIVE when wake_cnt == 0; idle_cnt clears on entry.
  - A request held through WAKE is granted in the first ACTIVE cycle.
- Simultaneous events:
  - A request arriving in the same cycle as the threshold blocks entry and clears idle_cnt.
  - ret_en_i dropping during WAKE has no effect; the wake sequence still completes.
- OBI rule: the requester holds req_i and its address/data stable until gnt_o. The block does not latch ungranted requests.

Optional Feature:
Macro CGRA_MEM_PORT_STATS_EN.
- Defined:
  - Adds input stats_clr_i (1 bit) and outputs rd_cnt_o and wr_cnt_o (32 bits each).
  - The counters increment on each granted read or write respectively and saturate at 0xFFFFFFFF.
  - A synchronous clear via stats_clr_i takes priority over increment.
  - Both counters reset to 0.
- Undefined: the ports and counters are absent. Access and retention behaviour are identical in both cases.

Test Plan:
- Reset, write 0xDEADBEEF with be = 4'hF to addr 5, then read addr 5 -> gnt_o in the request cycle, rvalid_o the next cycle, rdata_o = 0xDEADBEEF.
- Reads to addresses 0..7 on consecutive cycles -> 8 grants in 8 cycles, rvalid_o high for 8 consecutive cycles, data in order.
- ret_en_i = 1, no traffic, IDLE_CYCLES = 64 -> mem_set_retentive_o falls exactly 64 cycles after the last rvalid-free idle start; retentive_o = 1.
- In RETENTIVE, assert req_i (read addr 3) -> gnt_o stays 0 for 1 + WAKE_CYCLES cycles, then asserts once; rvalid_o the next cycle with stored data.
- Request in the same cycle idle_cnt reaches 63 -> no retention entry, idle_cnt restarts at 0. rst_ni = 0 during WAKE -> ACTIVE, mem_set_retentive_o = 1, rvalid_o = 0 next cycle.
- With CGRA_MEM_PORT_STATS_EN: 3 writes and 5 reads -> wr_cnt_o = 3, rd_cnt_o = 5. stats_clr_i pulsed -> both counters 0 next cycle.

Source files
------------

// File: rtl/cgra_mem_port_ctrl.sv
// OBI-style front end for one CGRA SRAM bank, with an idle-driven retention sequencer.
// Optional access counters are enabled by defining CGRA_MEM_PORT_STATS_EN.
module cgra_mem_port_ctrl #(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES = 4,
  localparam int unsigned AddrWidth  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [AddrWidth-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [3:0]            be_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  ret_en_i,
  output logic                  retentive_o,
`ifdef CGRA_MEM_PORT_STATS_EN
  input  logic                  stats_clr_i,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o,
`endif
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AddrWidth-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  output logic                  mem_set_retentive_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned IdleW = $clog2(IDLE_CYCLES);
  localparam int unsigned WakeW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(IDLE_CYCLES - 1);
  localparam logic [WakeW-1:0] WakeLoad = WakeW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_RETENTIVE = 2'd1,
    ST_WAKE      = 2'd2
  } state_e;

  state_e            state_r;
  state_e            state_s;
  logic [IdleW-1:0]  idle_cnt_r;
  logic [IdleW-1:0]  idle_cnt_s;
  logic [WakeW-1:0]  wake_cnt_r;
  logic [WakeW-1:0]  wake_cnt_s;
  logic              gnt_s;
  logic              rvalid_r;
  logic              rsp_read_r;

  assign gnt_s               = req_i & (state_r == ST_ACTIVE);
  assign gnt_o               = gnt_s;
  assign mem_req_o           = gnt_s;
  assign mem_we_o            = we_i;
  assign mem_addr_o          = addr_i;
  assign mem_wdata_o         = wdata_i;
  assign mem_be_o            = be_i;
  assign rvalid_o            = rvalid_r;
  assign retentive_o         = (state_r == ST_RETENTIVE);
  assign mem_set_retentive_o = (state_r != ST_RETENTIVE);

  // Bank data only belongs on the bus for read responses; write responses return zero.
  always_comb begin
    rdata_o = {DATA_WIDTH{1'b0}};
    if (rvalid_r && rsp_read_r) begin
      rdata_o = mem_rdata_i;
    end else begin
      rdata_o = {DATA_WIDTH{1'b0}};
    end
  end

  // Retention sequencer next-state and counter logic.
  always_comb begin
    state_s    = state_r;
    idle_cnt_s = idle_cnt_r;
    wake_cnt_s = wake_cnt_r;
    case (state_r)
      ST_ACTIVE: begin
        wake_cnt_s = {WakeW{1'b0}};
        if (req_i || !ret_en_i) begin
          // A request landing on the threshold cycle also blocks entry here.
          idle_cnt_s = {IdleW{1'b0}};
        end else if (idle_cnt_r == IdleMax) begin
          state_s    = ST_RETENTIVE;
          idle_cnt_s = idle_cnt_r;
        end else begin
          idle_cnt_s = idle_cnt_r + {{(IdleW-1){1'b0}}, 1'b1};
        end
      end
      ST_RETENTIVE: begin
        idle_cnt_s = {IdleW{1'b0}};
        if (req_i || !ret_en_i) begin
          state_s    = ST_WAKE;
          wake_cnt_s = WakeLoad;
        end else begin
          wake_cnt_s = wake_cnt_r;
        end
      end
      ST_WAKE: begin
        // ret_en_i is ignored here so the bank always finishes its wake-up.
        idle_cnt_s = {IdleW{1'b0}};
        if (wake_cnt_r == {WakeW{1'b0}}) begin
          state_s = ST_ACTIVE;
        end else begin
          wake_cnt_s = wake_cnt_r - {{(WakeW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s    = ST_ACTIVE;
        idle_cnt_s = {IdleW{1'b0}};
        wake_cnt_s = {WakeW{1'b0}};
      end
    endcase
  end

  // Sequencer state, counters and the one-cycle response pipeline.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= ST_ACTIVE;
      idle_cnt_r <= {IdleW{1'b0}};
      wake_cnt_r <= {WakeW{1'b0}};
      rvalid_r   <= 1'b0;
      rsp_read_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idle_cnt_r <= idle_cnt_s;
      wake_cnt_r <= wake_cnt_s;
      rvalid_r   <= gnt_s;
      rsp_read_r <= gnt_s & ~we_i;
    end
  end

`ifdef CGRA_MEM_PORT_STATS_EN
  // Saturating granted-access counters; clear wins over increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt_o <= 32'd0;
      wr_cnt_o <= 32'd0;
    end else if (stats_clr_i) begin
      rd_cnt_o <= 32'd0;
      wr_cnt_o <= 32'd0;
    end else begin
      if (gnt_s && !we_i && (rd_cnt_o != 32'hFFFF_FFFF)) begin
        rd_cnt_o <= rd_cnt_o + 32'd1;
      end else begin
        rd_cnt_o <= rd_cnt_o;
      end
      if (gnt_s && we_i && (wr_cnt_o != 32'hFFFF_FFFF)) begin
        wr_cnt_o <= wr_cnt_o + 32'd1;
      end else begin
        wr_cnt_o <= wr_cnt_o;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule
